// File: rtl/ram_arb_pkg.sv
// Shared sizing constants for the dual-port RAM arbiter and its round-robin cells.
package ram_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 12;
  localparam int unsigned DATA_W_DEF = 64;
  localparam int unsigned NUM_REQ    = 2;
  localparam int unsigned HAZ_W      = 16;

endpackage : ram_arb_pkg

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter: combinational grant, pointer flips after each grant.
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic               clock,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] gnt
);

  // ptr == 1 means requester 1 wins a tie
  logic ptr;

  always_comb begin
    gnt = '0;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = ptr ? 2'b10 : 2'b01;
      default: gnt = '0;
    endcase
  end

  // After a grant, favour whichever requester did not just win
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= 1'b0;
    end else if (advance && (|gnt)) begin
      ptr <= gnt[0];
    end
  end

endmodule : rr_arb2

// File: rtl/ram_port_arbiter.sv
// Arbitrates two writers and two readers onto a single-write/single-read RAM,
// stalling a read that collides with a same-cycle write to the same address.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        wr_req,
  input  logic [NUM_REQ*ADDR_W-1:0] wr_addr,
  input  logic [NUM_REQ*DATA_W-1:0] wr_data,
  output logic [NUM_REQ-1:0]        wr_gnt,
  input  logic [NUM_REQ-1:0]        rd_req,
  input  logic [NUM_REQ*ADDR_W-1:0] rd_addr,
  output logic [NUM_REQ-1:0]        rd_gnt,
  output logic [NUM_REQ-1:0]        rd_valid,
  output logic [DATA_W-1:0]         rd_data,
  output logic                      write,
  output logic [ADDR_W-1:0]         wr_address,
  output logic [DATA_W-1:0]         data_in,
  output logic                      read,
  output logic [ADDR_W-1:0]         rd_address,
  input  logic [DATA_W-1:0]         data_out,
  output logic [HAZ_W-1:0]          hazard_cnt
);

  logic [NUM_REQ-1:0] wr_cand;
  logic [NUM_REQ-1:0] rd_cand;
  logic [ADDR_W-1:0]  wr_sel_addr;
  logic [DATA_W-1:0]  wr_sel_data;
  logic [ADDR_W-1:0]  rd_sel_addr;
  logic               hazard;
  logic               rd_advance;
  logic [NUM_REQ-1:0] rd_inflight;

  rr_arb2 u_wr_arb (
    .clock   (clock),
    .reset_n (reset_n),
    .req     (wr_req),
    .advance (1'b1),
    .gnt     (wr_cand)
  );

  rr_arb2 u_rd_arb (
    .clock   (clock),
    .reset_n (reset_n),
    .req     (rd_req),
    .advance (rd_advance),
    .gnt     (rd_cand)
  );

  // Select the candidate requester's payload on each port
  always_comb begin
    wr_sel_addr = wr_cand[1] ? wr_addr[2*ADDR_W-1:ADDR_W] : wr_addr[ADDR_W-1:0];
    wr_sel_data = wr_cand[1] ? wr_data[2*DATA_W-1:DATA_W] : wr_data[DATA_W-1:0];
    rd_sel_addr = rd_cand[1] ? rd_addr[2*ADDR_W-1:ADDR_W] : rd_addr[ADDR_W-1:0];
  end

  // A read to the address being written this cycle waits one cycle so it sees the new data
  always_comb begin
    hazard     = reset_n && (|wr_cand) && (|rd_cand) && (rd_sel_addr == wr_sel_addr);
    rd_advance = !hazard;
    wr_gnt     = wr_cand & {NUM_REQ{reset_n}};
    rd_gnt     = hazard ? '0 : (rd_cand & {NUM_REQ{reset_n}});
  end

  assign rd_data = data_out;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      write       <= 1'b0;
      wr_address  <= '0;
      data_in     <= '0;
      read        <= 1'b0;
      rd_address  <= '0;
      rd_inflight <= '0;
      rd_valid    <= '0;
      hazard_cnt  <= '0;
    end else begin
      write       <= |wr_gnt;
      read        <= |rd_gnt;
      rd_inflight <= rd_gnt;
      rd_valid    <= rd_inflight;
      if (|wr_gnt) begin
        wr_address <= wr_sel_addr;
        data_in    <= wr_sel_data;
      end
      if (|rd_gnt) begin
        rd_address <= rd_sel_addr;
      end
      if (hazard && (hazard_cnt != {HAZ_W{1'b1}})) begin
        hazard_cnt <= hazard_cnt + HAZ_W'(1);
      end
    end
  end

endmodule : ram_port_arbiter

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural RAM on the strobe ports.
module tb_ram_port_arbiter;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 64;

  logic          clock;
  logic          reset_n;
  logic [1:0]    wr_req;
  logic [2*AW-1:0] wr_addr;
  logic [2*DW-1:0] wr_data;
  logic [1:0]    wr_gnt;
  logic [1:0]    rd_req;
  logic [2*AW-1:0] rd_addr;
  logic [1:0]    rd_gnt;
  logic [1:0]    rd_valid;
  logic [DW-1:0] rd_data;
  logic          write;
  logic [AW-1:0] wr_address;
  logic [DW-1:0] data_in;
  logic          read;
  logic [AW-1:0] rd_address;
  logic [DW-1:0] data_out;
  logic [15:0]   hazard_cnt;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .wr_req     (wr_req),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_gnt     (wr_gnt),
    .rd_req     (rd_req),
    .rd_addr    (rd_addr),
    .rd_gnt     (rd_gnt),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .write      (write),
    .wr_address (wr_address),
    .data_in    (data_in),
    .read       (read),
    .rd_address (rd_address),
    .data_out   (data_out),
    .hazard_cnt (hazard_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous RAM: write commits at the edge, read data appears the cycle after read
  always @(posedge clock) begin
    if (write) mem[wr_address] <= data_in;
    if (read)  data_out <= mem[rd_address];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n  = 1'b0;
    wr_req   = 2'b11;
    rd_req   = 2'b11;
    wr_addr  = '0;
    wr_data  = '0;
    rd_addr  = {12'h001, 12'h002};
    data_out = '0;
    tick();
    tick();
    // Reset state, with requests asserted to prove grants are masked
    chk("rst_wr_gnt", 64'(wr_gnt), 64'h0);
    chk("rst_rd_gnt", 64'(rd_gnt), 64'h0);
    chk("rst_write", 64'(write), 64'h0);
    chk("rst_read", 64'(read), 64'h0);
    chk("rst_rd_valid", 64'(rd_valid), 64'h0);
    chk("rst_hazard", 64'(hazard_cnt), 64'h0);
    chk("rst_wr_address", 64'(wr_address), 64'h0);
    chk("rst_rd_address", 64'(rd_address), 64'h0);
    chk("rst_data_in", 64'(data_in), 64'h0);

    wr_req = 2'b00;
    rd_req = 2'b00;
    #2 reset_n = 1'b1;
    tick();

    // Both writers held: grants alternate starting at requester 0
    wr_req  = 2'b11;
    wr_addr = {12'h101, 12'h100};
    wr_data = {64'h2, 64'h1};
    #1 chk("rr_gnt0", 64'(wr_gnt), 64'h1);
    tick();
    chk("rr_gnt1", 64'(wr_gnt), 64'h2);
    chk("rr_addr0", 64'(wr_address), 64'h100);
    tick();
    chk("rr_gnt2", 64'(wr_gnt), 64'h1);
    chk("rr_addr1", 64'(wr_address), 64'h101);
    tick();
    chk("rr_gnt3", 64'(wr_gnt), 64'h2);
    chk("rr_data0", 64'(data_in), 64'h1);
    tick();
    wr_req = 2'b00;
    #1 chk("rr_idle_gnt", 64'(wr_gnt), 64'h0);
    chk("rr_last_write", 64'(write), 64'h1);
    chk("rr_last_data", 64'(data_in), 64'h2);

    // Single write from requester 0
    tick();
    wr_req  = 2'b01;
    wr_addr = {12'h000, 12'h010};
    wr_data = {64'h0, 64'hA5};
    #1 chk("w0_gnt", 64'(wr_gnt), 64'h1);
    tick();
    wr_req = 2'b00;
    chk("w0_write", 64'(write), 64'h1);
    chk("w0_addr", 64'(wr_address), 64'h010);
    chk("w0_data", 64'(data_in), 64'hA5);
    tick();
    chk("w0_strobe_low", 64'(write), 64'h0);
    chk("w0_addr_hold", 64'(wr_address), 64'h010);
    chk("w0_data_hold", 64'(data_in), 64'hA5);

    // Write 0x55 then read the same address the next cycle from requester 1
    wr_req  = 2'b10;
    wr_addr = {12'h020, 12'h000};
    wr_data = {64'h55, 64'h0};
    #1 chk("wr1_gnt", 64'(wr_gnt), 64'h2);
    tick();
    wr_req  = 2'b00;
    rd_req  = 2'b10;
    rd_addr = {12'h020, 12'h000};
    #1 chk("rd1_gnt", 64'(rd_gnt), 64'h2);
    chk("rd1_no_hazard", 64'(hazard_cnt), 64'h0);
    tick();
    rd_req = 2'b00;
    chk("rd1_read", 64'(read), 64'h1);
    chk("rd1_rd_address", 64'(rd_address), 64'h020);
    chk("rd1_valid_early", 64'(rd_valid), 64'h0);
    tick();
    chk("rd1_valid", 64'(rd_valid), 64'h2);
    chk("rd1_data", 64'(rd_data), 64'h55);
    tick();
    chk("rd1_valid_drop", 64'(rd_valid), 64'h0);

    // Same-cycle write and read to 0x030: read stalls one cycle
    wr_req  = 2'b01;
    wr_addr = {12'h000, 12'h030};
    wr_data = {64'h0, 64'h77};
    rd_req  = 2'b01;
    rd_addr = {12'h000, 12'h030};
    #1 chk("hz_wr_gnt", 64'(wr_gnt), 64'h1);
    chk("hz_rd_gnt", 64'(rd_gnt), 64'h0);
    tick();
    wr_req = 2'b00;
    #1 chk("hz_count", 64'(hazard_cnt), 64'h1);
    chk("hz_rd_retry", 64'(rd_gnt), 64'h1);
    chk("hz_write", 64'(write), 64'h1);
    tick();
    rd_req = 2'b00;
    chk("hz_read", 64'(read), 64'h1);
    chk("hz_rd_address", 64'(rd_address), 64'h030);
    tick();
    chk("hz_valid", 64'(rd_valid), 64'h1);
    chk("hz_data", 64'(rd_data), 64'h77);
    chk("hz_count_hold", 64'(hazard_cnt), 64'h1);

    // Reset one cycle after a read grant drops the read
    tick();
    rd_req  = 2'b01;
    rd_addr = {12'h000, 12'h020};
    #1 chk("rr_rd_gnt", 64'(rd_gnt), 64'h1);
    tick();
    rd_req  = 2'b00;
    reset_n = 1'b0;
    #1 chk("mid_rst_read", 64'(read), 64'h0);
    chk("mid_rst_write", 64'(write), 64'h0);
    chk("mid_rst_valid", 64'(rd_valid), 64'h0);
    chk("mid_rst_hazard", 64'(hazard_cnt), 64'h0);
    tick();
    chk("mid_rst_valid2", 64'(rd_valid), 64'h0);
    reset_n = 1'b1;
    wr_req  = 2'b11;
    wr_addr = {12'h201, 12'h200};
    wr_data = {64'hB2, 64'hB1};
    rd_req  = 2'b11;
    rd_addr = {12'h301, 12'h300};
    #1 chk("post_rst_wr_gnt", 64'(wr_gnt), 64'h1);
    chk("post_rst_rd_gnt", 64'(rd_gnt), 64'h1);
    tick();
    chk("post_rst_valid", 64'(rd_valid), 64'h0);
    chk("post_rst_wr_addr", 64'(wr_address), 64'h200);
    chk("post_rst_rd_addr", 64'(rd_address), 64'h300);
    chk("post_rst_wr_gnt2", 64'(wr_gnt), 64'h2);
    chk("post_rst_rd_gnt2", 64'(rd_gnt), 64'h2);
    wr_req = 2'b00;
    rd_req = 2'b00;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_ram_port_arbiter
